cnt_track: RTL

CNT_TRACK -- requirements
Module: cnt_track

---
 rtl/cnt_track_if.sv | 13 +
 rtl/cnt_track.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cnt_track_if.sv
// Event channel between cnt_track and its consumer.
// Latency: none, wires only.
// Backpressure: consumer holds ev_ready low to stall; the head stays put until it is taken.
interface cnt_track_if #(
   parameter int WIDTH = 12
);
   logic             ev_valid;
   logic [WIDTH+1:0] ev_data;
   logic             ev_ready;

   modport master (output ev_valid, output ev_data, input ev_ready);
   modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/cnt_track.sv
// Small first-word-fall-through FIFO; a write while full is accepted only when a pop frees a slot.
// Latency: a write is visible at the head the cycle after its edge.
// Backpressure: rd_rdy low holds the head; full is exported so the writer can account for losses.
module cnt_track_fifo #(
   parameter int W     = 14,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         rd_vld,
   output logic [W-1:0] rd_dat,
   input  logic         rd_rdy,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  used;
   logic         pop;
   logic         wr_en;

   assign used   = wr_ptr - rd_ptr;
   assign full   = (used == (AW+1)'(DEPTH));
   assign rd_vld = (wr_ptr != rd_ptr);
   // Data reads as zero when empty so an idle or reset channel shows a clean bus.
   assign rd_dat = rd_vld ? mem[rd_ptr[AW-1:0]] : '0;
   assign pop    = rd_vld & rd_rdy;
   assign wr_en  = wr_vld & (~full | pop);

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since rd_vld gates them.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end
endmodule

// Unwraps a 4-bit upstream count, checks its step size and queues WRAP/ERR events.
// Latency: ext_cnt/wrap/err one cycle after the sampling edge; events at the FIFO head one cycle after it.
// Backpressure: ev_ready low holds the head; events arriving while the FIFO is full are dropped and counted.
module cnt_track #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             en,
   input  logic [3:0]       cnt,
   input  logic [3:0]       delta_exp = 4'd10,
   input  logic             clr,
   output logic [WIDTH-1:0] ext_cnt,
   output logic             wrap,
   output logic             err,
   cnt_track_if.master      ev,
   output logic [7:0]       drop_cnt
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] ERROR = 2'd2;

   localparam logic [1:0] EV_WRAP = 2'b01;
   localparam logic [1:0] EV_ERR  = 2'b10;

   logic [1:0]       state;
   logic [3:0]       prev;
   logic [3:0]       d;
   logic [WIDTH-1:0] sum;
   logic             sample;
   logic             mismatch;
   logic             crossed;
   logic             push;
   logic [WIDTH+1:0] push_dat;
   logic             fifo_full;
   logic             fifo_vld;
   logic [WIDTH+1:0] fifo_dat;
   logic             pop;

   // Step decode for a tracked sample; clr wins over en so a clearing cycle never samples.
   assign d        = cnt - prev;
   assign sum      = ext_cnt + WIDTH'(d);
   assign sample   = en & ~clr & (state == TRACK);
   assign mismatch = (d != delta_exp);
   assign crossed  = (cnt < prev);
   // A mismatching sample reports ERR only, even if it also wrapped.
   assign push     = sample & (mismatch | crossed);
   assign push_dat = {(mismatch ? EV_ERR : EV_WRAP), sum};
   assign pop      = fifo_vld & ev.ev_ready;
   assign err      = (state == ERROR);

   // Tracking FSM with the unwrapped count and the one-cycle wrap pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         prev    <= '0;
         ext_cnt <= '0;
         wrap    <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (en) begin
                     prev    <= cnt;
                     ext_cnt <= WIDTH'(cnt);
                     state   <= TRACK;
                  end
               end
               TRACK: begin
                  if (en) begin
                     prev    <= cnt;
                     ext_cnt <= sum;
                     wrap    <= crossed;
                     if (mismatch) state <= ERROR;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

   // Loss counter: a push finds no room only when full with no pop on the same edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         drop_cnt <= '0;
      end else if (push && fifo_full && !pop && (drop_cnt != 8'hff)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   cnt_track_fifo #(
      .W     (WIDTH + 2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .wr_vld (push),
      .wr_dat (push_dat),
      .rd_vld (fifo_vld),
      .rd_dat (fifo_dat),
      .rd_rdy (ev.ev_ready),
      .full   (fifo_full)
   );

   assign ev.ev_valid = fifo_vld;
   assign ev.ev_data  = fifo_dat;
endmodule
